// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 2;

    typedef enum logic [2:0] {
        StHdr0,
        StHdr1,
        StLo,
        StHi,
        StDone,
        StErr
    } load_state_e;

    // A frame must carry at least one word and no more than fits in memory.
    function automatic logic count_ok(input logic [HDR_BYTES*8-1:0] count,
                                      input int unsigned addr_w);
        return (count != '0) && (32'(count) <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader, plus status.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 9
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic              mem_wren;
    logic              load_busy;
    logic              start_pulse;
    logic              load_err;

    modport master (
        input  rx_data, rx_valid,
        output mem_addr, mem_data, mem_wren, load_busy, start_pulse, load_err
    );

    modport slave (
        output rx_data, rx_valid,
        input  mem_addr, mem_data, mem_wren, load_busy, start_pulse, load_err
    );

endinterface

// File: rtl/loader_timeout.sv
// Idle-cycle counter: cleared on demand, counts while enabled, saturates at TIMEOUT.
module loader_timeout #(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Assembles a length-prefixed little-endian byte stream into 16-bit words, writes them
// to instruction memory and fires a one-cycle start pulse after a complete load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.master bus
);

    localparam int unsigned CNT_W  = HDR_BYTES * 8;
    localparam int unsigned WORD_W = WORD_BYTES * 8;

    load_state_e       state_q, state_d;
    logic [7:0]        count_lo_q, count_lo_d;
    logic [7:0]        low_q, low_d;
    logic [ADDR_W:0]   word_addr_q, word_addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_data_q, mem_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic              busy_q, busy_d;
    logic              start_q, start_d;
    logic              err_q, err_d;

    logic [CNT_W-1:0]  hdr_count;
    logic              counting;
    logic              timed_out;

    assign hdr_count = {bus.rx_data, count_lo_q};
    assign counting  = (state_q == StHdr1) || (state_q == StLo) || (state_q == StHi);

    loader_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (bus.rx_valid || !counting),
        .enable  (counting),
        .expired (timed_out)
    );

    always_comb begin
        state_d     = state_q;
        count_lo_d  = count_lo_q;
        low_d       = low_q;
        word_addr_d = word_addr_q;
        remaining_d = remaining_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_wren_d  = 1'b0;
        busy_d      = busy_q;
        start_d     = 1'b0;
        err_d       = err_q;

        unique case (state_q)
            StHdr0: begin
                if (bus.rx_valid) begin
                    count_lo_d = bus.rx_data;
                    busy_d     = 1'b1;
                    state_d    = StHdr1;
                end
            end
            StHdr1: begin
                if (bus.rx_valid) begin
                    if (count_ok(hdr_count, ADDR_W)) begin
                        err_d       = 1'b0;
                        word_addr_d = '0;
                        remaining_d = hdr_count[ADDR_W:0];
                        state_d     = StLo;
                    end else begin
                        state_d = StErr;
                    end
                end else if (timed_out) begin
                    state_d = StErr;
                end
            end
            StLo: begin
                if (bus.rx_valid) begin
                    low_d   = bus.rx_data;
                    state_d = StHi;
                end else if (timed_out) begin
                    state_d = StErr;
                end
            end
            StHi: begin
                if (bus.rx_valid) begin
                    // The count check keeps word_addr below the top; never write past it.
                    if (!word_addr_q[ADDR_W]) begin
                        mem_wren_d = 1'b1;
                        mem_addr_d = word_addr_q[ADDR_W-1:0];
                        mem_data_d = {bus.rx_data, low_q};
                    end
                    word_addr_d = word_addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    state_d     = (remaining_q == (ADDR_W+1)'(1)) ? StDone : StLo;
                end else if (timed_out) begin
                    state_d = StErr;
                end
            end
            StDone: begin
                start_d = 1'b1;
                busy_d  = 1'b0;
                state_d = StHdr0;
            end
            StErr: begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = StHdr0;
            end
            default: begin
                state_d = StHdr0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StHdr0;
            count_lo_q  <= '0;
            low_q       <= '0;
            word_addr_q <= '0;
            remaining_q <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_wren_q  <= 1'b0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_lo_q  <= count_lo_d;
            low_q       <= low_d;
            word_addr_q <= word_addr_d;
            remaining_q <= remaining_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_wren_q  <= mem_wren_d;
            busy_q      <= busy_d;
            start_q     <= start_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_data    = mem_data_q;
    assign bus.mem_wren    = mem_wren_q;
    assign bus.load_busy   = busy_q;
    assign bus.start_pulse = start_q;
    assign bus.load_err    = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, header errors, full-depth load, timeout, reset.
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    imem_loader_if #(.ADDR_W(9)) bus ();

    imem_loader #(
        .ADDR_W  (9),
        .TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int sp_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_wren === 1'b1) begin
            wr_addr.push_back(int'(bus.mem_addr));
            wr_data.push_back(int'(bus.mem_data));
            wr_cyc.push_back(cyc);
        end
        if (bus.start_pulse === 1'b1) sp_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wa(input int i);
        return (i < wr_addr.size()) ? 32'(wr_addr[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wd(input int i);
        return (i < wr_data.size()) ? 32'(wr_data[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wc(input int i);
        return (i < wr_cyc.size()) ? 32'(wr_cyc[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] sc(input int i);
        return (i < sp_cyc.size()) ? 32'(sp_cyc[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        sp_cyc.delete();
    endtask

    // Called at a falling edge; the byte is sampled on the next rising edge.
    task automatic send(input logic [7:0] b, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int seq_err;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_wren", bus.mem_wren, 0);
        check("rst_busy", bus.load_busy, 0);
        check("rst_start", bus.start_pulse, 0);
        check("rst_err", bus.load_err, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_data", bus.mem_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: back-to-back frame of two words
        clear_log();
        send(8'h02, 0);
        check("s1_busy_hdr", bus.load_busy, 1);
        send(8'h00, 0);
        send(8'h34, 0);
        send(8'h12, 0);
        send(8'hCD, 0);
        send(8'hAB, 0);
        repeat (5) @(negedge clk);
        check("s1_nwr", wr_addr.size(), 2);
        check("s1_a0", wa(0), 0);
        check("s1_d0", wd(0), 32'h1234);
        check("s1_a1", wa(1), 1);
        check("s1_d1", wd(1), 32'hABCD);
        check("s1_wr_gap", wc(1) - wc(0), 2);
        check("s1_nsp", sp_cyc.size(), 1);
        check("s1_sp_time", sc(0), wc(1) + 1);
        check("s1_err", bus.load_err, 0);
        check("s1_busy_end", bus.load_busy, 0);
        check("s1_hold_addr", bus.mem_addr, 1);
        check("s1_hold_data", bus.mem_data, 32'hABCD);

        // 2: zero count header, then a good one-word frame
        clear_log();
        send(8'h00, 0);
        send(8'h00, 0);
        repeat (3) @(negedge clk);
        check("s2_err", bus.load_err, 1);
        check("s2_busy", bus.load_busy, 0);
        check("s2_nwr", wr_addr.size(), 0);
        check("s2_nsp", sp_cyc.size(), 0);
        send(8'h01, 0);
        check("s2_err_hold", bus.load_err, 1);
        send(8'h00, 0);
        check("s2_err_clr", bus.load_err, 0);
        send(8'hEF, 0);
        send(8'hBE, 0);
        repeat (4) @(negedge clk);
        check("s2_nwr2", wr_addr.size(), 1);
        check("s2_a0", wa(0), 0);
        check("s2_d0", wd(0), 32'hBEEF);
        check("s2_nsp2", sp_cyc.size(), 1);

        // 3: oversize count rejected, full-depth count accepted
        clear_log();
        send(8'h01, 0);
        send(8'h02, 0);
        repeat (3) @(negedge clk);
        check("s3_err", bus.load_err, 1);
        check("s3_nwr", wr_addr.size(), 0);
        send(8'h00, 0);
        send(8'h02, 0);
        check("s3_err_clr", bus.load_err, 0);
        for (int i = 0; i < 512; i++) begin
            send(8'(i), 0);
            send(8'(i >> 8), 0);
        end
        repeat (4) @(negedge clk);
        check("s3_nwr2", wr_addr.size(), 512);
        seq_err = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] != i || wr_data[i] != i) seq_err++;
        end
        check("s3_seq", seq_err, 0);
        check("s3_last_a", wa(511), 32'h1FF);
        check("s3_nsp", sp_cyc.size(), 1);
        check("s3_sp_time", sc(0), wc(511) + 1);
        check("s3_err_end", bus.load_err, 0);

        // 4: stall mid-frame until the idle timeout fires
        clear_log();
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        repeat (17) @(negedge clk);
        check("s4_err_early", bus.load_err, 0);
        check("s4_busy_early", bus.load_busy, 1);
        @(negedge clk);
        check("s4_err", bus.load_err, 1);
        check("s4_busy", bus.load_busy, 0);
        repeat (3) @(negedge clk);
        check("s4_nwr", wr_addr.size(), 1);
        check("s4_d0", wd(0), 32'h2211);
        check("s4_a0", wa(0), 0);
        check("s4_nsp", sp_cyc.size(), 0);

        // 5: asynchronous reset while waiting for a high byte
        clear_log();
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        check("s5_pre_data", bus.mem_data, 32'h2211);
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_data", bus.mem_data, 0);
        check("s5_rst_busy", bus.load_busy, 0);
        check("s5_rst_wren", bus.mem_wren, 0);
        check("s5_rst_err", bus.load_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'h78, 0);
        send(8'h56, 0);
        repeat (4) @(negedge clk);
        check("s5_nwr", wr_addr.size(), 1);
        check("s5_a0", wa(0), 0);
        check("s5_d0", wd(0), 32'h5678);
        check("s5_nsp", sp_cyc.size(), 1);

        // 6: same frame as 1 with idle gaps between bytes
        clear_log();
        send(8'h02, 3);
        send(8'h00, 3);
        send(8'h34, 3);
        send(8'h12, 3);
        send(8'hCD, 3);
        send(8'hAB, 3);
        repeat (3) @(negedge clk);
        check("s6_nwr", wr_addr.size(), 2);
        check("s6_a0", wa(0), 0);
        check("s6_d0", wd(0), 32'h1234);
        check("s6_a1", wa(1), 1);
        check("s6_d1", wd(1), 32'hABCD);
        check("s6_wr_gap", wc(1) - wc(0), 8);
        check("s6_nsp", sp_cyc.size(), 1);
        check("s6_sp_time", sc(0), wc(1) + 1);
        check("s6_err", bus.load_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
